uart_writer_buffer: RTL and testbench

Serializes one wide control/info word from the debug interface FSM into a sequence of UART bytes. It is the transmit-side counterpart of the debug controller's write request. The controller pulses a write request with a 56-bit status word. This block latches the word and hands it to the UART transmitter one byte at a time, most-significant byte first. When the last byte has been sent, it returns a single-cycle finish pulse.

---
 rtl/uart_writer_buffer.sv | 129 ++++++++++++
 tb/tb_uart_writer_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_writer_buffer.sv
// uart_writer_buffer
//   Takes one wide status word from the debug controller and passes it to a
//   byte-wide UART transmitter, most-significant byte first. When the last
//   byte has been sent, it raises a single-cycle finish pulse.
//
// Ports
//   i_clk           clock
//   i_reset         asynchronous, active-high reset
//   i_write         one-cycle write request; honoured only when idle
//   i_data          word to send; sampled only on an accepted i_write
//   i_tx_done       UART TX finished the current byte (one-cycle tick)
//   o_tx_start      one-cycle pulse that starts UART TX on o_tx_data
//   o_tx_data       byte presented to UART TX
//   o_busy          transfer in progress
//   o_write_finish  one-cycle pulse; the whole word has been sent
module uart_writer_buffer #(
    parameter int UART_DATA_LEN = 8,
    parameter int NUM_BYTES     = 7,
    parameter int DATA_LEN      = UART_DATA_LEN * NUM_BYTES
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_write,
    input  logic [DATA_LEN-1:0]      i_data,
    input  logic                     i_tx_done,
    output logic                     o_tx_start,
    output logic [UART_DATA_LEN-1:0] o_tx_data,
    output logic                     o_busy,
    output logic                     o_write_finish
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [2:0] LAST_BYTE = 3'(NUM_BYTES - 1);

    state_t                     state_q, state_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic [DATA_LEN-1:0]        shreg_q, shreg_d;
    logic                       tx_start_q, tx_start_d;
    logic [UART_DATA_LEN-1:0]   tx_data_q, tx_data_d;
    logic                       busy_q, busy_d;
    logic                       finish_q, finish_d;
    logic [DATA_LEN-1:0]        shifted;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        tx_start_d = 1'b0;       // start and finish are single-cycle pulses
        tx_data_d  = tx_data_q;  // held between bytes and after the transfer
        busy_d     = busy_q;
        finish_d   = 1'b0;
        // The next byte is the top byte of the word after it has been shifted
        shifted    = shreg_q << UART_DATA_LEN;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (i_write) begin
                    shreg_d    = i_data;
                    cnt_d      = '0;
                    tx_data_d  = i_data[DATA_LEN-1 -: UART_DATA_LEN];
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                // The start pulse is already on the output. A done tick that
                // arrives in this cycle cannot belong to this byte.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (cnt_q < LAST_BYTE) begin
                        cnt_d      = cnt_q + 3'd1;
                        shreg_d    = shifted;
                        tx_data_d  = shifted[DATA_LEN-1 -: UART_DATA_LEN];
                        tx_start_d = 1'b1;
                        state_d    = ST_SEND;
                    end else begin
                        finish_d = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // busy stays high through DONE and drops together with finish
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            finish_q   <= finish_d;
        end
    end

    assign o_tx_start     = tx_start_q;
    assign o_tx_data      = tx_data_q;
    assign o_busy         = busy_q;
    assign o_write_finish = finish_q;

endmodule

// File: tb/tb_uart_writer_buffer.sv
// Testbench for uart_writer_buffer. Each word's expected byte stream is taken
// directly from the word (MSB first). A negedge monitor records every started
// byte and every finish pulse, and watches pulse widths and o_tx_data stability.
module tb_uart_writer_buffer;

    localparam int NB = 7;

    logic        i_clk;
    logic        i_reset;
    logic        i_write;
    logic [55:0] i_data;
    logic        i_tx_done;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic        o_write_finish;

    uart_writer_buffer dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_write        (i_write),
        .i_data         (i_data),
        .i_tx_done      (i_tx_done),
        .o_tx_start     (o_tx_start),
        .o_tx_data      (o_tx_data),
        .o_busy         (o_busy),
        .o_write_finish (o_write_finish)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc_cnt = 0;
    int         fin_cnt = 0;
    int         pulse_err = 0;
    int         stab_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic       prev_busy = 1'b0;
    logic       prev_start = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge i_clk) begin
        if (i_reset) begin
            prev_busy  <= 1'b0;
            prev_start <= 1'b0;
        end else begin
            if (o_tx_start) obs_q.push_back(o_tx_data);
            if (o_write_finish) fin_cnt <= fin_cnt + 1;
            if ((o_tx_start && prev_start) || (o_tx_start && !o_busy))
                pulse_err <= pulse_err + 1;
            if (o_busy && prev_busy && !o_tx_start && o_tx_data !== prev_data)
                stab_err <= stab_err + 1;
            prev_busy  <= o_busy;
            prev_start <= o_tx_start;
            prev_data  <= o_tx_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input logic [55:0] w, input int k);
        return 8'((w >> (8 * (NB - 1 - k))) & 56'hFF);
    endfunction

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (o_tx_start) begin
                ok = 1'b1;
                return;
            end
            cyc();
        end
    endtask

    task automatic compare_bytes(input string tag);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_byte"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
        exp_q.delete();
        obs_q.delete();
    endtask

    // One full transfer. dly = cycles between a start pulse and the done tick
    // (>= 1). spur adds a done tick in each SEND cycle; inj pulses i_write
    // during byte 2 and during DONE.
    task automatic run_word(input string tag, input logic [55:0] w, input int dly,
                            input bit spur, input bit inj);
        int t0;
        int f0;
        bit ok;
        f0 = fin_cnt;
        for (int k = 0; k < NB; k++) exp_q.push_back(byte_of(w, k));
        i_write = 1'b1;
        i_data  = w;
        cyc();
        i_write = 1'b0;
        t0 = cyc_cnt;
        check({tag, "_busy_rise"}, 64'(o_busy), 64'd1);
        if (inj) i_data = 56'({$urandom(), $urandom()});
        for (int k = 0; k < NB; k++) begin
            wait_start(ok);
            check({tag, "_start_seen"}, 64'(ok), 64'd1);
            if (!ok) return;
            for (int c = 0; c < dly; c++) begin
                i_tx_done = spur && c == 0;
                i_write   = inj && k == 2 && c == 0;
                if (i_write) i_data = {7{8'hAA}};
                cyc();
            end
            i_write   = 1'b0;
            i_tx_done = 1'b1;
            cyc();
            i_tx_done = 1'b0;
        end
        check({tag, "_finish"}, 64'(o_write_finish), 64'd1);
        check({tag, "_busy_done"}, 64'(o_busy), 64'd1);
        i_write = inj;
        cyc();
        i_write = 1'b0;
        check({tag, "_finish_drop"}, 64'(o_write_finish), 64'd0);
        check({tag, "_busy_fall"}, 64'(o_busy), 64'd0);
        check({tag, "_no_restart"}, 64'(o_tx_start), 64'd0);
        check({tag, "_cycles"}, 64'(cyc_cnt - t0), 64'(NB * (dly + 1) + 1));
        check({tag, "_fin_count"}, 64'(fin_cnt - f0), 64'd1);
        compare_bytes(tag);
    endtask

    initial begin
        logic [55:0] w;
        bit          ok;
        int          f0;

        i_reset   = 1'b1;
        i_write   = 1'b0;
        i_data    = '0;
        i_tx_done = 1'b0;
        #2;
        check("rst_start", 64'(o_tx_start), 64'd0);
        check("rst_data", 64'(o_tx_data), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_finish", 64'(o_write_finish), 64'd0);
        cyc();
        cyc();
        i_reset = 1'b0;
        cyc();

        // Single word, MSB first
        run_word("single", 56'hFF000000000002, 3, 1'b0, 1'b0);

        // Minimum-latency transfer, then back-to-back words
        run_word("b2b0", 56'h00000000000001, 1, 1'b0, 1'b0);
        run_word("b2b1", 56'h00000000000003, 1, 1'b0, 1'b0);

        // Request while busy (during byte 2 and during DONE)
        run_word("busyreq", 56'h11223344556677, 2, 1'b0, 1'b1);

        // Spurious ticks in IDLE, then ticks in every SEND cycle
        i_tx_done = 1'b1;
        repeat (3) cyc();
        i_tx_done = 1'b0;
        check("idle_tick_start", 64'(o_tx_start), 64'd0);
        check("idle_tick_busy", 64'(o_busy), 64'd0);
        check("idle_tick_fin", 64'(o_write_finish), 64'd0);
        check("idle_tick_bytes", 64'(obs_q.size()), 64'd0);
        run_word("spur", 56'hC0FFEE12345678, 2, 1'b1, 1'b0);

        // Reset mid-transfer: three bytes complete, reset lands in byte 3's SEND cycle
        w  = 56'({$urandom(), $urandom()});
        f0 = fin_cnt;
        for (int k = 0; k < 3; k++) exp_q.push_back(byte_of(w, k));
        i_write = 1'b1;
        i_data  = w;
        cyc();
        i_write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_start(ok);
            check("rstmid_start_seen", 64'(ok), 64'd1);
            repeat (2) cyc();
            i_tx_done = 1'b1;
            cyc();
            i_tx_done = 1'b0;
        end
        check("rstmid_pre_start", 64'(o_tx_start), 64'd1);
        #2;
        i_reset = 1'b1;
        #1;
        check("rstmid_start", 64'(o_tx_start), 64'd0);
        check("rstmid_data", 64'(o_tx_data), 64'd0);
        check("rstmid_busy", 64'(o_busy), 64'd0);
        check("rstmid_finish", 64'(o_write_finish), 64'd0);
        cyc();
        cyc();
        i_reset = 1'b0;
        repeat (3) cyc();
        check("rstmid_idle_busy", 64'(o_busy), 64'd0);
        check("rstmid_no_fin", 64'(fin_cnt - f0), 64'd0);
        compare_bytes("rstmid");
        run_word("post_rst", 56'h02030405060708, 1, 1'b0, 1'b0);

        // Slow TX
        run_word("slow", 56'h5A5A0F0FF0A5C3, 100, 1'b0, 1'b0);

        // Random words, delays and disturbances
        for (int r = 0; r < 10; r++) begin
            w = 56'({$urandom(), $urandom()});
            run_word("rand", w, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end

        check("pulse_width", 64'(pulse_err), 64'd0);
        check("data_stable", 64'(stab_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
